// File: rtl/johnson_decoder_if.sv
// rtl/johnson_decoder_if.sv - code/decode bundle between a Johnson code source and johnson_decoder
//
// Purpose: groups the sampled-code input and the decoded/status outputs of
// johnson_decoder so they travel as one port.
// Ports (signals):
//   code_in    [N]   Johnson code under test
//   code_valid       code_in is sampled on cycles where this is high
//   idx_out    [IW]  decoded phase index
//   idx_valid        one-cycle pulse per sampled code
//   illegal          sample was not a legal Johnson code
//   seq_err          sample was legal but not the expected successor
//   locked           lock state machine is in LOCKED
//   err_cnt    [8]   saturating count of flagged samples
// Modports: master drives codes and observes results, slave is the decoder.

interface johnson_decoder_if #(
  parameter int N  = 4,
  parameter int IW = $clog2(2 * N)
);
  logic [N-1:0]  code_in;
  logic          code_valid;
  logic [IW-1:0] idx_out;
  logic          idx_valid;
  logic          illegal;
  logic          seq_err;
  logic          locked;
  logic [7:0]    err_cnt;

  modport master (
    output code_in, code_valid,
    input  idx_out, idx_valid, illegal, seq_err, locked, err_cnt
  );

  modport slave (
    input  code_in, code_valid,
    output idx_out, idx_valid, illegal, seq_err, locked, err_cnt
  );
endinterface

// File: rtl/johnson_decoder.sv
// rtl/johnson_decoder.sv - Johnson code to phase index decoder with sequence check and lock FSM
//
// Purpose: samples an N-bit Johnson code on each valid cycle, converts it to
// a binary phase index, flags illegal codes and out-of-sequence codes, and
// runs a HUNT/TRACK/LOCKED state machine with a saturating error counter.
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-high reset
//   bus    johnson_decoder_if.slave (code_in/code_valid in; idx_out, idx_valid,
//          illegal, seq_err, locked, err_cnt out)
// Latency: a code sampled at edge t is captured in an input register, and
// every output reflecting it updates at edge t+1.

module johnson_decoder #(
  parameter int N        = 4,
  parameter int LOCK_CNT = 4,
  parameter int MISS_MAX = 2
) (
  input  logic            clk,
  input  logic            reset,
  johnson_decoder_if.slave bus
);
  localparam int IW = $clog2(2 * N);
  localparam int GW = $clog2(LOCK_CNT + 1);
  localparam int MW = $clog2(MISS_MAX + 1);

  localparam logic [1:0] HUNT   = 2'd0;
  localparam logic [1:0] TRACK  = 2'd1;
  localparam logic [1:0] LOCKED = 2'd2;

  logic [N-1:0]  s_code;
  logic          s_valid;
  logic [1:0]    state;
  logic [N-1:0]  exp_code;
  logic [GW-1:0] good_cnt;
  logic [MW-1:0] miss_cnt;
  logic [IW-1:0] idx_q;
  logic          idx_valid_q;
  logic          illegal_q;
  logic          seq_err_q;
  logic [7:0]    err_cnt_q;

  logic          legal;
  logic [IW-1:0] dec_idx;
  logic          match;
  logic          seq_flag;
  logic          err_flag;

  function automatic logic [N-1:0] succ(input logic [N-1:0] c);
    return {~c[0], c[N-1:1]};
  endfunction

  // Legal code for phase k: k<=N -> top k bits set; k>N -> top k-N bits clear, rest set.
  function automatic logic [N-1:0] pattern(input int k);
    logic [N-1:0] p;
    p = '0;
    for (int b = 0; b < N; b++) begin
      p[N-1-b] = (k <= N) ? (b < k) : (b >= k - N);
    end
    return p;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      s_code  <= '0;
      s_valid <= 1'b0;
    end else begin
      s_valid <= bus.code_valid;
      if (bus.code_valid) s_code <= bus.code_in;
    end
  end

  always_comb begin
    legal   = 1'b0;
    dec_idx = '0;
    for (int k = 0; k < 2 * N; k++) begin
      if (s_code == pattern(k)) begin
        legal   = 1'b1;
        dec_idx = IW'(k);
      end
    end
  end

  assign match    = (s_code == exp_code);
  // HUNT has no reference yet, so a legal sample there is never a sequence error.
  assign seq_flag = legal && !match && (state != HUNT);
  assign err_flag = !legal || seq_flag;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= HUNT;
      exp_code    <= '0;
      good_cnt    <= '0;
      miss_cnt    <= '0;
      idx_q       <= '0;
      idx_valid_q <= 1'b0;
      illegal_q   <= 1'b0;
      seq_err_q   <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      idx_valid_q <= s_valid;
      illegal_q   <= 1'b0;
      seq_err_q   <= 1'b0;
      if (s_valid) begin
        idx_q     <= dec_idx;
        illegal_q <= !legal;
        seq_err_q <= seq_flag;
        if (err_flag && err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;

        case (state)
          HUNT: begin
            if (legal) begin
              exp_code <= succ(s_code);
              good_cnt <= GW'(1);
              state    <= TRACK;
            end
          end
          TRACK: begin
            if (!legal) begin
              good_cnt <= '0;
              state    <= HUNT;
            end else if (match) begin
              exp_code <= succ(s_code);
              good_cnt <= good_cnt + GW'(1);
              if (good_cnt == GW'(LOCK_CNT - 1)) begin
                miss_cnt <= '0;
                state    <= LOCKED;
              end
            end else begin
              exp_code <= succ(s_code);
              good_cnt <= GW'(1);
            end
          end
          LOCKED: begin
            // Flywheel: the reference advances regardless of the sample so a
            // single glitch cannot shift the tracked phase.
            exp_code <= succ(exp_code);
            if (legal && match) begin
              miss_cnt <= '0;
            end else if (miss_cnt == MW'(MISS_MAX - 1)) begin
              miss_cnt <= '0;
              good_cnt <= '0;
              state    <= HUNT;
            end else begin
              miss_cnt <= miss_cnt + MW'(1);
            end
          end
          default: begin
            good_cnt <= '0;
            miss_cnt <= '0;
            state    <= HUNT;
          end
        endcase
      end
    end
  end

  assign bus.idx_out   = idx_q;
  assign bus.idx_valid = idx_valid_q;
  assign bus.illegal   = illegal_q;
  assign bus.seq_err   = seq_err_q;
  assign bus.locked    = (state == LOCKED);
  assign bus.err_cnt   = err_cnt_q;
endmodule

// File: doc/johnson_decoder.md
# johnson_decoder

Receive-side companion to the N-bit Johnson counter. Samples an incoming N-bit Johnson code each valid cycle and converts it to a binary phase index. Checks that each code is a legal Johnson state and is the correct successor of the previous one. Runs a lock state machine and a saturating error counter so downstream logic (phase selection, clock-divider monitors) can trust the decoded index only while `locked` is high.

## Interface
- `N`, default 4: Johnson code width; the sequence has 2N states.
- `LOCK_CNT`, default 4: consecutive good sequential samples needed to reach LOCKED (≥2).
- `MISS_MAX`, default 2: consecutive bad samples in LOCKED that force a return to HUNT (≥1).
- `IW`, derived as $clog2(2N): index width (3 for N=4).
- `clk` input 1: the single clock; all logic is on its rising edge.
- `reset` input 1: synchronous, active-high reset.
- `code_in` input N: Johnson code under test.
- `code_valid` input 1: `code_in` is sampled only on cycles where this is high.
- `idx_out` output IW: decoded phase index, 0..2N-1.
- `idx_valid` output 1: one-cycle pulse, one cycle after each sampled code.
- `illegal` output 1: the sample was not one of the 2N legal codes (pulse aligned with `idx_valid`).
- `seq_err` output 1: the sample was legal but not the expected successor (pulse aligned with `idx_valid`).
- `locked` output 1: lock FSM is in LOCKED.
- `err_cnt` output 8: saturating count of samples flagged `illegal` or `seq_err`.

## Operation
- Sequence convention: next = {~code[0], code[N-1:1]}. For N=4: 0000→1000→1100→1110→1111→0111→0011→0001→0000.
- Index mapping:
  - k in 0..N: the top k bits are 1 and the rest are 0.
  - k in N+1..2N-1: the top k-N bits are 0 and the rest are 1.
  - Examples: 0000=0, 1110=3, 1111=4, 0111=5, 0001=7.
- Legality: legal iff the code matches one of the 2N patterns. Any other code is illegal and decodes to `idx_out`=0. For N=4 these include 0100, 1010, 0110 and 1001.
- Internal state:
  - `exp_code`: expected next code, equal to succ(last reference code).
  - Lock FSM with states HUNT, TRACK, LOCKED.
  - `good_cnt` and `miss_cnt`.
- HUNT:
  - Legal sample: reference becomes `code_in`; go to TRACK with `good_cnt`=1. No `seq_err`.
  - Illegal sample: stay in HUNT.
- TRACK:
  - Legal sample equal to `exp_code`: reference becomes `code_in` and `good_cnt`++. When `good_cnt` reaches `LOCK_CNT`, go to LOCKED with `miss_cnt`=0.
  - Legal sample not equal to `exp_code`: assert `seq_err`. Restart with reference = `code_in` and `good_cnt`=1; stay in TRACK.
  - Illegal sample: go to HUNT and clear `good_cnt`.
- LOCKED:
  - The reference always advances to `exp_code`, whether the sample is good or bad (flywheel). A single glitch therefore does not break phase.
  - Good sample (equal to `exp_code`): `miss_cnt`=0.
  - Bad sample (illegal, or legal but mismatched): `miss_cnt`++. When `miss_cnt` reaches `MISS_MAX`, go to HUNT and drop `locked`.
- `err_cnt`: increments by 1 on each flagged sample in any state and saturates at 255. It is cleared only by `reset`.
- Cycles with `code_valid`=0 change nothing. `idx_valid`, `illegal` and `seq_err` are 0 on those cycles; `idx_out` holds its last value.

## Timing
- Latency: all outputs are registered. The sample taken at edge t appears on `idx_out`, `idx_valid`, `illegal`, `seq_err` and `err_cnt` after edge t+1.
- `locked` rises in the same cycle that `idx_valid` reports the LOCK_CNT-th good sample. It falls in the same cycle that `idx_valid` reports the MISS_MAX-th miss.
- Reset values: `idx_out`=0, `idx_valid`=0, `illegal`=0, `seq_err`=0, `locked`=0, `err_cnt`=0. Internally the FSM is in HUNT and all counters are 0.
- Reset mid-stream: the effect is identical to power-up. A `code_valid` high on the reset cycle is ignored.
- Back-to-back valid samples are supported at full rate, one per clock.
- Wrap-around: 0001→0000 (index 7→0 for N=4) is a normal sequential step.
- Holding the same code for two valid samples counts as a sequence error (or a miss in LOCKED).

## Test plan
- Reset, then drive the 16-sample N=4 sequence starting at 0000 with `code_valid`=1 every cycle:
  - `idx_out` = 0,1,…,7,0,…
  - `locked` goes high with the 4th sample's output.
  - No flags; `err_cnt`=0.
- Locked, then one illegal 1010 in place of 1110:
  - `illegal`=1 and `idx_out`=0 for that sample.
  - `locked` stays 1 and the next 1111 is accepted.
  - `err_cnt`=1.
- Locked, then two consecutive repeats of 0011:
  - `seq_err` pulses twice.
  - `locked` drops with the second repeat's output.
  - The following legal code re-enters TRACK.
- In TRACK after 2 good samples, jump 1100→0111: `seq_err`=1, `good_cnt` restarts, and lock is reached 3 good samples later.
- Gapped `code_valid` (1,0,0,1,…) carrying a correct sequence: locks after 4 valid samples; no flags during the gaps.
- 300 illegal samples (0100): `err_cnt` saturates at 255; `locked`=0 throughout. Asserting `reset` mid-run clears everything on the next edge.
